// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product-in / frame-total-out bus for mac_accumulator
//   slave  : the accumulator (takes products, drives totals)
//   master : the producer/consumer side (drives products, takes totals)
interface mac_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int FRAME_LEN = 16
);
  logic                             clear;
  logic                             in_valid;
  logic                             in_ready;
  logic [2*WIDTH-1:0]               product;
  logic                             out_valid;
  logic                             out_ready;
  logic [ACC_WIDTH-1:0]             acc_out;
  logic                             ovf_out;
  logic [$clog2(FRAME_LEN+1)-1:0]   sample_cnt;
  modport slave (
    input  clear, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, ovf_out, sample_cnt
  );
  modport master (
    output clear, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, ovf_out, sample_cnt
  );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums FRAME_LEN products per frame, holds one total until consumed
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mac_accumulator_if.slave (clear, in_valid/in_ready/product,
//             out_valid/out_ready/acc_out/ovf_out, sample_cnt)
//   SATURATE_EN defined: accumulator clamps to all-ones on overflow; else wraps.
module mac_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mac_accumulator_if.slave  bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH must be >= 2*WIDTH");
  end
  if (FRAME_LEN < 1) begin : g_bad_len
    $error("FRAME_LEN must be >= 1");
  end
  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t               r_state, w_state_nx;
  logic [ACC_WIDTH-1:0] r_acc, r_acc_out, w_acc_nx;
  logic [CW-1:0]        r_cnt;
  logic                 r_sticky, r_ovf_out;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_accept, w_last, w_ovf;
  assign w_accept = bus.in_valid && r_state == ACCUM;
  assign w_last   = r_cnt == CW'(FRAME_LEN - 1);
  // One extra bit catches the carry out of the accumulator.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - 2 * WIDTH){1'b0}}, bus.product};
  assign w_ovf    = r_sticky | w_sum[ACC_WIDTH];
`ifdef SATURATE_EN
  // Once the frame has overflowed the total stays pinned at all-ones.
  assign w_acc_nx = w_ovf ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_nx = w_sum[ACC_WIDTH-1:0];
`endif
  always_comb begin
    w_state_nx = bus.clear                            ? ACCUM :
                 (w_accept && w_last)                 ? DRAIN :
                 (r_state == DRAIN && bus.out_ready)  ? ACCUM : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_acc_out <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (bus.clear) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (w_accept && w_last) begin
        r_acc_out <= w_acc_nx;
        r_ovf_out <= w_ovf;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_sticky  <= 1'b0;
      end else if (w_accept) begin
        r_acc    <= w_acc_nx;
        r_cnt    <= r_cnt + CW'(1);
        r_sticky <= w_ovf;
      end
    end
  end
  assign bus.in_ready   = r_state == ACCUM;
  assign bus.out_valid  = r_state == DRAIN;
  assign bus.acc_out    = r_acc_out;
  assign bus.ovf_out    = r_ovf_out;
  assign bus.sample_cnt = r_cnt;
endmodule
